// File: rtl/mux2_arbiter_if.sv
// Bundle between two producers, the mux2_arbiter and the shared downstream consumer.
// Under MUX2_ARB_STATS_EN the bundle also carries the per-requester grant counters.
interface mux2_arbiter_if #(
    parameter int unsigned W = 1
);
    logic [1:0]   req;
    logic [1:0]   last;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         ready_in;
    logic         valid_out;
    logic [W-1:0] d_out;
    logic         sel;
    logic [1:0]   gnt;
    logic [1:0]   ack;
`ifdef MUX2_ARB_STATS_EN
    logic [15:0]  gnt_cnt0;
    logic [15:0]  gnt_cnt1;

    modport master (
        output req, last, d0, d1, ready_in,
        input  valid_out, d_out, sel, gnt, ack, gnt_cnt0, gnt_cnt1
    );
    modport slave (
        input  req, last, d0, d1, ready_in,
        output valid_out, d_out, sel, gnt, ack, gnt_cnt0, gnt_cnt1
    );
`else
    modport master (
        output req, last, d0, d1, ready_in,
        input  valid_out, d_out, sel, gnt, ack
    );
    modport slave (
        input  req, last, d0, d1, ready_in,
        output valid_out, d_out, sel, gnt, ack
    );
`endif
endinterface

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter/sequencer owning the select of a shared 2:1 mux with forced rotation.
// Optional grant statistics are enabled with `define MUX2_ARB_STATS_EN.
module mux2_arbiter #(
    parameter int unsigned W         = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input logic            clk,
    input logic            rst_n,
    mux2_arbiter_if.slave  arb_if
);
    localparam int unsigned CW = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e        state_q, state_d;
    logic          sel_q, sel_d;
    logic          prio_q, prio_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own_c;
    logic          cap_hit_c;
    logic          valid_c;
    logic          accept_c;
    logic          burst_end_c;
    logic [W-1:0]  d_mux_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            prio_q  <= 1'b0;
            gnt_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // In an OWN state sel already names the owner, so it doubles as the owner index.
    assign own_c     = sel_q;
    assign cap_hit_c = (MAX_BURST != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        valid_c     = 1'b0;
        accept_c    = 1'b0;
        burst_end_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_if.req == 2'b11)  state_d = prio_q ? OWN1 : OWN0;
                else if (arb_if.req[0])   state_d = OWN0;
                else if (arb_if.req[1])   state_d = OWN1;
            end
            OWN0, OWN1: begin
                valid_c  = arb_if.req[own_c];
                accept_c = valid_c & arb_if.ready_in;
                if (!arb_if.req[own_c] || (accept_c && (arb_if.last[own_c] || cap_hit_c)))
                    burst_end_c = 1'b1;
                else if (accept_c)
                    cnt_d = cnt_q + CW'(1);
                // Hand over without a bubble; otherwise re-grant with a fresh count.
                if (burst_end_c) begin
                    prio_d = ~own_c;
                    cnt_d  = '0;
                    if (arb_if.req[~own_c])    state_d = own_c ? OWN0 : OWN1;
                    else if (arb_if.req[own_c]) state_d = own_c ? OWN1 : OWN0;
                    else                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (MAX_BURST == 0) cnt_d = '0;
        if (state_d == OWN0)      sel_d = 1'b0;
        else if (state_d == OWN1) sel_d = 1'b1;
        gnt_d = {state_d == OWN1, state_d == OWN0};
    end

    assign d_mux_c          = sel_q ? arb_if.d1 : arb_if.d0;
    assign arb_if.d_out     = d_mux_c;
    assign arb_if.valid_out = valid_c;
    assign arb_if.ack       = {accept_c & own_c, accept_c & ~own_c};
    assign arb_if.sel       = sel_q;
    assign arb_if.gnt       = gnt_q;

`ifdef MUX2_ARB_STATS_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt1_q;
    logic        enter0_c, enter1_c;

    // Every entry into an OWN state counts, including a re-grant to the same owner.
    assign enter0_c = (state_d == OWN0) && ((state_q != OWN0) || burst_end_c);
    assign enter1_c = (state_d == OWN1) && ((state_q != OWN1) || burst_end_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q <= 16'h0000;
            gnt_cnt1_q <= 16'h0000;
        end else begin
            if (enter0_c && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
            if (enter1_c && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
        end
    end

    assign arb_if.gnt_cnt0 = gnt_cnt0_q;
    assign arb_if.gnt_cnt1 = gnt_cnt1_q;
`endif
endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: producers push expected beats, a negedge monitor checks accepts.
module tb_mux2_arbiter;
    localparam int unsigned W = 1;

    typedef struct {
        logic [W-1:0] d;
        logic         last;
    } beat_t;

    typedef struct {
        logic [1:0]   gnt;
        logic [W-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic rdy = 1'b1;
    logic kill0 = 1'b0;
    int   stats_n = 0;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_q[$];

    mux2_arbiter_if #(.W(W)) bus ();

    mux2_arbiter #(.W(W), .MAX_BURST(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: every accepted beat must match the next expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: gnt=%b d=%h accepted, none expected", bus.gnt, bus.d_out);
            end else begin
                e = exp_q.pop_front();
                chk("beat_gnt", 32'(bus.gnt), 32'(e.gnt));
                chk("beat_ack", 32'(bus.ack), 32'(e.gnt));
                chk("beat_d", 32'(bus.d_out), 32'(e.d));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive();
        bus.req      = {q1.size() > 0, (q0.size() > 0) && !kill0};
        bus.last[0]  = (q0.size() > 0) ? q0[0].last : 1'b0;
        bus.last[1]  = (q1.size() > 0) ? q1[0].last : 1'b0;
        bus.d0       = (q0.size() > 0) ? q0[0].d : '0;
        bus.d1       = (q1.size() > 0) ? q1[0].d : '0;
        bus.ready_in = rdy;
    endtask

    // One cycle: present heads, remember acks seen before the edge, retire acked beats.
    task automatic step();
        logic [1:0] a;
        drive();
        @(negedge clk);
        a = bus.ack;
        @(posedge clk);
        #1;
        if (a[0] && q0.size() > 0) void'(q0.pop_front());
        if (a[1] && q1.size() > 0) void'(q1.pop_front());
        drive();
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [W-1:0] d);
        exp_t e;
        e.gnt = g;
        e.d   = d;
        exp_q.push_back(e);
    endtask

    task automatic add_beat(input int who, input logic [W-1:0] d, input logic l);
        beat_t b;
        b.d    = d;
        b.last = l;
        if (who == 0) q0.push_back(b);
        else          q1.push_back(b);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        kill0 = 1'b0;
        rdy   = 1'b1;
        drive();
        #1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs producers until both queues drain; cycles lo..hi are stalled with ready_in=0.
    task automatic drain(input logic [1:0] first_gnt, input int lo, input int hi, output int n);
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
            n++;
            rdy = !(n >= lo && n <= hi);
            if (!rdy) begin
                drive();
                #1;
                chk("stall_valid", 32'(bus.valid_out), 32'd1);
                chk("stall_ack", 32'(bus.ack), 32'd0);
                chk("stall_d", 32'(bus.d_out), 32'(q0[0].d));
                chk("stall_gnt", 32'(bus.gnt), 32'd1);
            end
            step();
            if (n == 1) chk("first_gnt", 32'(bus.gnt), 32'(first_gnt));
`ifdef MUX2_ARB_STATS_EN
            if (n == stats_n) begin
                chk("stats_cnt0", 32'(bus.gnt_cnt0), 32'd2);
                chk("stats_cnt1", 32'(bus.gnt_cnt1), 32'd1);
            end
`endif
        end
        rdy = 1'b1;
        if (n >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d cycles, queues %0d/%0d", n, q0.size(), q1.size());
        end
    endtask

    task automatic idle_check(input string nm);
        step();
        chk({nm, "_idle_gnt"}, 32'(bus.gnt), 32'd0);
        chk({nm, "_idle_valid"}, 32'(bus.valid_out), 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] p0;
        logic [3:0] p1;
        drive();

        // Single requester 1: three beats 1,0,1 with last on the third.
        do_reset();
        add_beat(1, 1'b1, 1'b0);
        add_beat(1, 1'b0, 1'b0);
        add_beat(1, 1'b1, 1'b1);
        push_exp(2'b10, 1'b1);
        push_exp(2'b10, 1'b0);
        push_exp(2'b10, 1'b1);
        drain(2'b10, 1000, 0, n);
        chk("single_cycles", 32'(n), 32'd4);
        idle_check("single");

        // Fairness: both requesting, no last; 4-beat rotation with no bubble.
        do_reset();
        p0 = 8'b1001_0110;
        p1 = 4'b1010;
        for (int i = 0; i < 8; i++) add_beat(0, p0[i], 1'b0);
        for (int i = 0; i < 4; i++) add_beat(1, p1[i], 1'b0);
        for (int i = 0; i < 4; i++) push_exp(2'b01, p0[i]);
        for (int i = 0; i < 4; i++) push_exp(2'b10, p1[i]);
        for (int i = 4; i < 8; i++) push_exp(2'b01, p0[i]);
        stats_n = 9;
        drain(2'b01, 1000, 0, n);
        stats_n = 0;
        chk("fair_cycles", 32'(n), 32'd13);
        idle_check("fair");

        // Backpressure: 2 accepts, 3 stalled cycles, rotation after 4 accepts in total.
        do_reset();
        p0 = 8'b0000_0110;
        p1 = 4'b1001;
        for (int i = 0; i < 4; i++) add_beat(0, p0[i], 1'b0);
        for (int i = 0; i < 4; i++) add_beat(1, p1[i], 1'b0);
        for (int i = 0; i < 4; i++) push_exp(2'b01, p0[i]);
        for (int i = 0; i < 4; i++) push_exp(2'b10, p1[i]);
        drain(2'b01, 4, 6, n);
        chk("bp_cycles", 32'(n), 32'd12);
        idle_check("bp");

        // Withdrawal: requester 0 drops req mid-burst, requester 1 takes over next cycle.
        do_reset();
        add_beat(0, 1'b1, 1'b0);
        add_beat(0, 1'b0, 1'b0);
        add_beat(1, 1'b1, 1'b1);
        push_exp(2'b01, 1'b1);
        push_exp(2'b10, 1'b1);
        step();
        chk("wd_gnt0", 32'(bus.gnt), 32'd1);
        step();
        kill0 = 1'b1;
        step();
        chk("wd_gnt1", 32'(bus.gnt), 32'd2);
        step();
        idle_check("wd");
        // Priority after the withdrawal sequence favours requester 0 again.
        q0.delete();
        kill0 = 1'b0;
        add_beat(0, 1'b1, 1'b1);
        add_beat(1, 1'b0, 1'b1);
        push_exp(2'b01, 1'b1);
        push_exp(2'b10, 1'b0);
        drain(2'b01, 1000, 0, n);
        idle_check("wd_prio");

        // Reset in the middle of a requester-1 burst drops the in-flight beat.
        do_reset();
        add_beat(1, 1'b1, 1'b0);
        add_beat(1, 1'b0, 1'b0);
        add_beat(1, 1'b1, 1'b1);
        push_exp(2'b10, 1'b1);
        step();
        chk("mid_gnt", 32'(bus.gnt), 32'd2);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
        chk("mid_rst_valid", 32'(bus.valid_out), 32'd0);
        chk("mid_rst_ack", 32'(bus.ack), 32'd0);
        chk("mid_rst_sel", 32'(bus.sel), 32'd0);
        q1.delete();
        exp_q.delete();
        add_beat(0, 1'b1, 1'b1);
        add_beat(1, 1'b0, 1'b1);
        push_exp(2'b01, 1'b1);
        push_exp(2'b10, 1'b0);
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain(2'b01, 1000, 0, n);
        idle_check("mid");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
